// File: rtl/rd_beat_splitter_pkg.sv
// Shared widths, defaults and beat payload layout for the MIG read-beat splitter.
package rd_beat_splitter_pkg;

  localparam int unsigned IN_W        = 256;
  localparam int unsigned OUT_W       = 128;
  localparam int unsigned OB_COUNT_W  = 7;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned OB_HIGH_DEF = 120;

  // One MIG beat: lo is emitted first, hi second.
  typedef struct packed {
    logic [OUT_W-1:0] hi;
    logic [OUT_W-1:0] lo;
  } beat_t;

endpackage

// File: rtl/rd_beat_splitter_if.sv
// MIG read-return and output-FIFO write signals seen by the beat splitter.
interface rd_beat_splitter_if;
  import rd_beat_splitter_pkg::*;

  logic                  rd_issue;
  logic                  rd_credit_ok;
  logic [IN_W-1:0]       app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;
  logic                  ob_we;
  logic [OUT_W-1:0]      ob_data;
  logic                  ob_full;
  logic [OB_COUNT_W-1:0] ob_count;

  // Environment side: MIG plus output FIFO.
  modport master (
    output rd_issue, app_rd_data, app_rd_data_valid, app_rd_data_end, ob_full, ob_count,
    input  rd_credit_ok, ob_we, ob_data
  );

  // Splitter side.
  modport slave (
    input  rd_issue, app_rd_data, app_rd_data_valid, app_rd_data_end, ob_full, ob_count,
    output rd_credit_ok, ob_we, ob_data
  );

endinterface

// File: rtl/beat_ram.sv
// DEPTH x 256-bit beat store: one synchronous write port, asynchronous read.
module beat_ram
  import rd_beat_splitter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  beat_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output beat_t                    rdata
);

  beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rd_beat_splitter.sv
// Buffers 256-bit MIG read beats and emits each as two 128-bit FIFO writes,
// tracking outstanding reads so the issuer never overruns the buffer.
module rd_beat_splitter
  import rd_beat_splitter_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned OB_HIGH = OB_HIGH_DEF
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  rd_beat_splitter_if.slave      bus,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err,
  output logic                   credit_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [CW-1:0] OCC_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] OUT_MAX  = '1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          half;
  logic [CW-1:0] outstanding;
  logic          ob_we_c;
  logic          free_c;
  logic          store_c;
  logic          beat_c;
  beat_t         head;
  logic          unused_end;

  // Beats are always BL8 single-beat returns, so the end marker carries no information.
  assign unused_end = bus.app_rd_data_end;
  assign beat_c     = bus.app_rd_data_valid;

  // A full buffer can still accept a beat when the head is freed on the same edge.
  always_comb begin
    ob_we_c = 1'b0;
    free_c  = 1'b0;
    store_c = 1'b0;
    ob_we_c = (occupancy != '0) && !bus.ob_full && (32'(bus.ob_count) < OB_HIGH);
    free_c  = ob_we_c && half;
    store_c = beat_c && ((occupancy != OCC_FULL) || free_c);
  end

  assign bus.ob_we        = ob_we_c;
  assign bus.ob_data      = half ? head.hi : head.lo;
  assign bus.rd_credit_ok = (SW'(outstanding) + SW'(occupancy)) < SW'(DEPTH);

  beat_ram #(.DEPTH(DEPTH)) u_beat_ram (
    .clk   (sys_clk),
    .we    (store_c),
    .waddr (wr_ptr),
    .wdata (beat_t'(bus.app_rd_data)),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Buffer pointers, half-select and occupancy.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      half      <= 1'b0;
      occupancy <= '0;
    end else begin
      if (store_c) wr_ptr <= wr_ptr + AW'(1);
      if (free_c)  rd_ptr <= rd_ptr + AW'(1);
      if (ob_we_c) half   <= !half;
      if (store_c && !free_c)      occupancy <= occupancy + CW'(1);
      else if (free_c && !store_c) occupancy <= occupancy - CW'(1);
    end
  end

  // Outstanding reads: issue and return in the same cycle cancel out.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
    end else if (bus.rd_issue && !beat_c) begin
      if (outstanding != OUT_MAX) outstanding <= outstanding + CW'(1);
    end else if (!bus.rd_issue && beat_c && (outstanding != '0)) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  // Sticky error flags.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      overflow_err <= 1'b0;
      credit_err   <= 1'b0;
    end else begin
      if (beat_c && !store_c)              overflow_err <= 1'b1;
      if (beat_c && (outstanding == '0))   credit_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rd_beat_splitter.sv
// Directed self-checking bench for rd_beat_splitter (DEPTH=4, OB_HIGH=120).
module tb_rd_beat_splitter;

  logic       clk;
  logic       rstn;
  logic [2:0] occupancy;
  logic       overflow_err;
  logic       credit_err;
  int         checks;
  int         errors;

  localparam logic [127:0] W_A = {16{8'hAA}};
  localparam logic [127:0] W_B = {16{8'hBB}};
  localparam logic [127:0] W_C = {16{8'hCC}};
  localparam logic [127:0] W_D = {16{8'hDD}};
  localparam logic [127:0] W_E = {16{8'hEE}};
  localparam logic [127:0] W_F = {16{8'hFF}};
  localparam logic [127:0] W_G = {16{8'h11}};
  localparam logic [127:0] W_H = {16{8'h22}};

  rd_beat_splitter_if bus ();

  rd_beat_splitter #(.DEPTH(4), .OB_HIGH(120)) dut (
    .sys_clk      (clk),
    .rstn         (rstn),
    .bus          (bus),
    .occupancy    (occupancy),
    .overflow_err (overflow_err),
    .credit_err   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.rd_issue          = 1'b0;
    bus.app_rd_data       = '0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data_end   = 1'b0;
    bus.ob_full           = 1'b0;
    bus.ob_count          = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic issue_reads(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rd_issue = 1'b1;
    end
    @(negedge clk);
    bus.rd_issue = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.ob_we !== 1'b0) begin errors++; $display("FAIL reset_ob_we got %b exp 0", bus.ob_we); end
    checks++; if (bus.rd_credit_ok !== 1'b1) begin errors++; $display("FAIL reset_credit_ok got %b exp 1", bus.rd_credit_ok); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow_err got %b exp 0", overflow_err); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err got %b exp 0", credit_err); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_beat();
    do_reset();
    issue_reads(1);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_B, W_A};
    #1;
    checks++; if (bus.ob_we !== 1'b0) begin errors++; $display("FAIL single_no_early_we got %b exp 0", bus.ob_we); end
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ1 got %0d exp 1", occupancy); end
    checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== W_A) begin errors++; $display("FAIL single_lo got we=%b data=%h exp we=1 data=%h", bus.ob_we, bus.ob_data, W_A); end
    @(negedge clk); #1;
    checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== W_B) begin errors++; $display("FAIL single_hi got we=%b data=%h exp we=1 data=%h", bus.ob_we, bus.ob_data, W_B); end
    @(negedge clk); #1;
    checks++; if (bus.ob_we !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL single_done got we=%b occ=%0d exp we=0 occ=0", bus.ob_we, occupancy); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL single_credit_err got %b exp 0", credit_err); end
  endtask

  task automatic test_credit();
    do_reset();
    issue_reads(4);
    #1;
    checks++; if (bus.rd_credit_ok !== 1'b0) begin errors++; $display("FAIL credit_four_issued got %b exp 0", bus.rd_credit_ok); end
    @(negedge clk);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_D, W_C};
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (bus.rd_credit_ok !== 1'b0) begin errors++; $display("FAIL credit_beat_held got %b exp 0", bus.rd_credit_ok); end
    checks++; if (bus.ob_data !== W_C) begin errors++; $display("FAIL credit_lo_data got %h exp %h", bus.ob_data, W_C); end
    @(negedge clk); #1;
    checks++; if (bus.rd_credit_ok !== 1'b0) begin errors++; $display("FAIL credit_after_lo got %b exp 0", bus.rd_credit_ok); end
    @(negedge clk); #1;
    checks++; if (bus.rd_credit_ok !== 1'b1) begin errors++; $display("FAIL credit_after_hi got %b exp 1", bus.rd_credit_ok); end
  endtask

  task automatic test_backpressure();
    do_reset();
    issue_reads(4);
    bus.ob_count = 7'd120;
    for (int k = 0; k < 4; k++) begin
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data       = {128'(32'hC000 + 2 * k + 1), 128'(32'hC000 + 2 * k)};
      #1;
      checks++; if (bus.ob_we !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got %b exp 0", k, bus.ob_we); end
      @(negedge clk);
    end
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd4 || bus.ob_we !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d we=%b exp occ=4 we=0", occupancy, bus.ob_we); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL bp_overflow_err got %b exp 0", overflow_err); end
    bus.ob_count = 7'd119;
    for (int w = 0; w < 8; w++) begin
      #1;
      checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== 128'(32'hC000 + w)) begin errors++; $display("FAIL bp_drain_%0d got we=%b data=%h exp we=1 data=%h", w, bus.ob_we, bus.ob_data, 128'(32'hC000 + w)); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.ob_we !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL bp_empty got we=%b occ=%0d exp we=0 occ=0", bus.ob_we, occupancy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_reads(5);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_F, W_E};
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_warmup_occ got %0d exp 0", occupancy); end
    for (int k = 0; k < 9; k++) begin
      bus.app_rd_data_valid = (k < 4);
      bus.app_rd_data       = {128'(32'hB000 + 2 * k + 1), 128'(32'hB000 + 2 * k)};
      #1;
      if (k == 0) begin
        checks++; if (bus.ob_we !== 1'b0) begin errors++; $display("FAIL b2b_first got we=%b exp 0", bus.ob_we); end
      end else begin
        checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== 128'(32'hB000 + k - 1)) begin errors++; $display("FAIL b2b_word_%0d got we=%b data=%h exp we=1 data=%h", k - 1, bus.ob_we, bus.ob_data, 128'(32'hB000 + k - 1)); end
      end
      @(negedge clk);
    end
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (bus.ob_we !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL b2b_end got we=%b occ=%0d exp we=0 occ=0", bus.ob_we, occupancy); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.ob_full = 1'b1;
    issue_reads(5);
    for (int k = 0; k < 5; k++) begin
      bus.app_rd_data_valid = 1'b1;
      bus.app_rd_data       = {128'(32'hD000 + 2 * k + 1), 128'(32'hD000 + 2 * k)};
      #1;
      if (k == 4) begin
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_before got %b exp 0", overflow_err); end
      end
      @(negedge clk);
    end
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_err); end
    checks++; if (occupancy !== 3'd4 || bus.ob_we !== 1'b0) begin errors++; $display("FAIL ovf_occ got occ=%0d we=%b exp occ=4 we=0", occupancy, bus.ob_we); end
    bus.ob_full = 1'b0;
    for (int w = 0; w < 8; w++) begin
      #1;
      checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== 128'(32'hD000 + w)) begin errors++; $display("FAIL ovf_drain_%0d got we=%b data=%h exp we=1 data=%h", w, bus.ob_we, bus.ob_data, 128'(32'hD000 + w)); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.ob_we !== 1'b0 || overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_after got we=%b ovf=%b exp we=0 ovf=1", bus.ob_we, overflow_err); end
    issue_reads(3);
    #1;
    checks++; if (bus.rd_credit_ok !== 1'b1) begin errors++; $display("FAIL ovf_outstanding_dec got credit_ok=%b exp 1", bus.rd_credit_ok); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    issue_reads(1);
    bus.rd_issue          = 1'b1;
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_B, W_A};
    @(negedge clk);
    bus.rd_issue          = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (occupancy !== 3'd0 || credit_err !== 1'b0) begin errors++; $display("FAIL sim_drained got occ=%0d cerr=%b exp occ=0 cerr=0", occupancy, credit_err); end
    issue_reads(2);
    #1;
    checks++; if (bus.rd_credit_ok !== 1'b1) begin errors++; $display("FAIL sim_outstanding3 got credit_ok=%b exp 1", bus.rd_credit_ok); end
    issue_reads(1);
    #1;
    checks++; if (bus.rd_credit_ok !== 1'b0) begin errors++; $display("FAIL sim_outstanding4 got credit_ok=%b exp 0", bus.rd_credit_ok); end
    // Unsolicited beat: flagged, still buffered, outstanding stays at zero.
    do_reset();
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_D, W_C};
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL sim_credit_err got %b exp 1", credit_err); end
    checks++; if (occupancy !== 3'd1 || bus.ob_data !== W_C) begin errors++; $display("FAIL sim_stored got occ=%0d data=%h exp occ=1 data=%h", occupancy, bus.ob_data, W_C); end
    @(negedge clk);
    @(negedge clk);
    issue_reads(3);
    #1;
    checks++; if (bus.rd_credit_ok !== 1'b1 || credit_err !== 1'b1) begin errors++; $display("FAIL sim_zero_outstanding got credit_ok=%b cerr=%b exp 1 1", bus.rd_credit_ok, credit_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    checks++; if (credit_err !== 1'b0 || overflow_err !== 1'b0) begin errors++; $display("FAIL mid_flags_cleared got cerr=%b ovf=%b exp 0 0", credit_err, overflow_err); end
    issue_reads(1);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_F, W_E};
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== W_E) begin errors++; $display("FAIL mid_lo got we=%b data=%h exp we=1 data=%h", bus.ob_we, bus.ob_data, W_E); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (bus.ob_we !== 1'b0 || occupancy !== 3'd0 || bus.rd_credit_ok !== 1'b1) begin errors++; $display("FAIL mid_reset got we=%b occ=%0d credit_ok=%b exp 0 0 1", bus.ob_we, occupancy, bus.rd_credit_ok); end
    @(negedge clk);
    rstn = 1'b1;
    issue_reads(1);
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data       = {W_H, W_G};
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    #1;
    checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== W_G) begin errors++; $display("FAIL mid_restart_lo got we=%b data=%h exp we=1 data=%h", bus.ob_we, bus.ob_data, W_G); end
    @(negedge clk); #1;
    checks++; if (bus.ob_we !== 1'b1 || bus.ob_data !== W_H) begin errors++; $display("FAIL mid_restart_hi got we=%b data=%h exp we=1 data=%h", bus.ob_we, bus.ob_data, W_H); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();
    test_reset();
    test_single_beat();
    test_credit();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_beat_splitter.md
RD_BEAT_SPLITTER -- requirements
Module: rd_beat_splitter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DEPTH, 4, 256-bit beat buffer entries (power of 2, >=2).
REQ-002 OB_HIGH, 120, output-FIFO write-count threshold; no writes at or above it.
REQ-003 Clocking SHALL be one clock, sys_clk; reset SHALL be asynchronous and active-low, rstn.
REQ-004 Ports (name, direction, width, meaning):
- sys_clk  in  1  MIG ui clock.
- rstn  in  1  async active-low reset.
- rd_issue  in  1  one-cycle pulse per read command accepted by MIG (app_en & app_rdy & read cmd).
- rd_credit_ok  out  1  a further read may be issued.
- app_rd_data  in  256  MIG read beat.
- app_rd_data_valid  in  1  beat qualifier; no backpressure possible.
- app_rd_data_end  in  1  ignored (BL8, one beat per command).
- ob_we  out  1  output FIFO write enable.
- ob_data  out  128  output FIFO write data.
- ob_full  in  1  output FIFO full.
- ob_count  in  7  output FIFO write data count.
- occupancy  out  $clog2(DEPTH)+1  beats held.
- overflow_err  out  1  sticky: beat dropped.
- credit_err  out  1  sticky: beat arrived with zero outstanding reads.

Function
REQ-005 Block SHALL buffer each valid 256-bit beat in a DEPTH-entry circular buffer and emit it as two 128-bit words: [127:0] first, then [255:128].
REQ-006 Write pointer, read pointer and half-select SHALL wrap modulo DEPTH with no gap cycle.
REQ-007 A beat valid at edge t SHALL be stored at t; earliest ob_we for it SHALL be cycle t+1.
REQ-008 ob_we SHALL be combinational: occupancy!=0 & !ob_full & ob_count<OB_HIGH; ob_data SHALL be the selected half of the head entry.
REQ-009 Each ob_we cycle SHALL toggle half-select; the upper-half write SHALL free the head entry and advance the read pointer.
REQ-010 Outstanding counter SHALL +1 on rd_issue, -1 on valid beat, and hold when both occur in the same cycle.
REQ-011 rd_credit_ok SHALL be (outstanding + occupancy) < DEPTH, combinational from registers.
REQ-012 A beat with a full buffer SHALL be dropped, set overflow_err, and still decrement outstanding.
REQ-013 A beat with outstanding==0 SHALL set credit_err, be stored if space exists, and leave outstanding at 0.
REQ-014 Same-cycle store and free SHALL leave occupancy unchanged, including at occupancy==DEPTH.
REQ-015 rd_issue while rd_credit_ok==0 SHALL still be counted; outstanding SHALL saturate at its maximum.
REQ-016 Sticky flags SHALL clear only on reset.

Reset
REQ-017 rstn low SHALL asynchronously clear pointers, half-select, occupancy, outstanding and both flags.
REQ-018 While rstn is low: ob_we=0, rd_credit_ok=1, occupancy=0.
REQ-019 Reset mid-transfer SHALL discard buffered beats and any half-emitted beat; buffer contents need not be cleared.
REQ-020 Deassertion SHALL be synchronised to sys_clk by the parent.

Structure
REQ-021 Shared package SHALL hold IN_W=256, OUT_W=128, OB_COUNT_W=7 and the default DEPTH/OB_HIGH.
REQ-022 Beat storage SHALL be one sub-module, beat_ram: DEPTH x 256, one write port, async read.
REQ-023 Pointers, counters and flags SHALL stay in rd_beat_splitter.

Verification
REQ-024 Single beat: rd_issue, then beat 256'h{B..B,A..A} with ob_full=0, ob_count=0 -> ob_we on the two following cycles with A..A then B..B; occupancy back to 0.
REQ-025 Credit: 4 rd_issue, no data, DEPTH=4 -> rd_credit_ok=0; one beat arrives and drains -> rd_credit_ok=1 after the upper-half write.
REQ-026 Backpressure: ob_count=120 while 4 beats arrive -> ob_we stays 0, occupancy=4; ob_count=0 -> 8 consecutive ob_we in arrival order.
REQ-027 Overflow: 5 beats with ob_full=1, DEPTH=4 -> 5th dropped, overflow_err=1, occupancy=4.
REQ-028 Simultaneous events: rd_issue and beat in the same cycle at outstanding=1 -> outstanding stays 1; beat with outstanding=0 -> credit_err=1.
REQ-029 Reset mid-transfer: rstn low after the lower-half write -> ob_we=0 immediately; after release the next beat emits its lower half first.
